// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and default bit timing.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HI
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous serial line; both stages reset to the idle level 1.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic serial,
  output logic synced
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= serial;
      sync_reg <= meta_reg;
    end
  end

  assign synced = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, mid-bit sampling, valid/ready byte output.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_i,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun,
`ifdef UART_RX_PARITY_EN
  output logic                      parity_err,
`endif
  output logic                      busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      line;
  rx_state_t                 state_reg;
  logic [CW-1:0]             cnt_reg;
  logic [2:0]                bit_idx_reg;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                      deliver_reg;
  logic [UART_DATA_BITS-1:0] data_reg;
  logic                      valid_reg;
  logic                      frame_err_reg;
  logic                      overrun_reg;
`ifdef UART_RX_PARITY_EN
  logic                      parity_bit_reg;
  logic                      parity_err_reg;
`endif

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .serial (rx_i),
    .synced (line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      deliver_reg   <= 1'b0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      deliver_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          cnt_reg     <= '0;
          bit_idx_reg <= '0;
          if (!line) state_reg <= START;
        end
        START: begin
          if (cnt_reg == HALF_M1) begin
            cnt_reg   <= '0;
            state_reg <= line ? IDLE : DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (cnt_reg == FULL_M1) begin
            cnt_reg                <= '0;
            shift_reg[bit_idx_reg] <= line;
            bit_idx_reg            <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_reg == FULL_M1) begin
            cnt_reg        <= '0;
            parity_bit_reg <= line;
            state_reg      <= STOP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`endif
        // Returning to IDLE at mid-stop lets an immediately following start bit be caught.
        STOP: begin
          if (cnt_reg == FULL_M1) begin
            cnt_reg <= '0;
            if (line) begin
              state_reg <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (^{shift_reg, parity_bit_reg}) parity_err_reg <= 1'b1;
              else                              deliver_reg    <= 1'b1;
`else
              deliver_reg <= 1'b1;
`endif
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= WAIT_HI;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_HI: begin
          cnt_reg <= '0;
          if (line) state_reg <= IDLE;
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase

      // A full holding register that is not being drained keeps its byte; the new one is lost.
      if (deliver_reg) begin
        if (valid_reg && !rx_ready) begin
          overrun_reg <= 1'b1;
        end else begin
          data_reg  <= shift_reg;
          valid_reg <= 1'b1;
        end
      end else if (valid_reg && rx_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign rx_data   = data_reg;
  assign rx_valid  = valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: table of single frames plus corner-case sequences.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx_i;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_i),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miss_cnt = 0;

  // Event counters sampled on the falling edge, where all DUT outputs are settled.
  int         valid_cycles = 0;
  int         acc_cnt = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         perr_cnt = 0;
  logic [7:0] last_acc = 8'h00;

  always @(negedge clk) begin
    if (rx_valid) valid_cycles++;
    if (rx_valid && rx_ready) begin
      last_acc = rx_data;
      acc_cnt++;
    end
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt++;
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Leaves the caller 2 ns after a rising edge, where inputs are changed.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ ~par_ok);
`else
    if (!par_ok) $display("note: parity request ignored in 8N1 build");
`endif
    drive_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  int v0, f0, o0, p0;

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h80, 1'b1, 1, 0};
    vecs[4] = '{8'h01, 1'b1, 1, 0};
    vecs[5] = '{8'hC3, 1'b0, 0, 1};
    vecs[6] = '{8'h96, 1'b1, 1, 0};

    rst = 1'b1; rx_i = 1'b1; rx_ready = 1'b0;
    tick(4);
    @(negedge clk);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_ferr", frame_err, 0);
    check("reset_ovr", overrun, 0);
    tick(1);
    rst = 1'b0;
    tick(4);

    // Table-driven single frames with the consumer always ready.
    rx_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(vecs[k].data, vecs[k].stop, 1'b1);
      rx_i = 1'b1;
      tick(2 * CPB);
      check($sformatf("vec%0d_valid_cycles", k), valid_cycles - v0, vecs[k].exp_valid);
      check($sformatf("vec%0d_ferr", k), ferr_cnt - f0, vecs[k].exp_ferr);
      check($sformatf("vec%0d_ovr", k), ovr_cnt - o0, 0);
      if (vecs[k].exp_valid != 0) check($sformatf("vec%0d_data", k), last_acc, vecs[k].data);
    end

    // Short low glitch must be rejected at the start-bit check.
    v0 = valid_cycles; f0 = ferr_cnt;
    rx_i = 1'b0;
    tick(4);
    rx_i = 1'b1;
    tick(10);
    @(negedge clk);
    check("glitch_busy_idle", busy, 0);
    tick(2 * CPB);
    check("glitch_valid", valid_cycles - v0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);

    // Framing error, held break, then a clean frame.
    v0 = valid_cycles; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    tick(40);
    rx_i = 1'b1;
    tick(2 * CPB);
    check("ferr_pulse", ferr_cnt - f0, 1);
    check("ferr_no_valid", valid_cycles - v0, 0);
    send_frame(8'h3C, 1'b1, 1'b1);
    tick(2 * CPB);
    check("after_ferr_valid", valid_cycles - v0, 1);
    check("after_ferr_data", last_acc, 8'h3C);
    check("after_ferr_no_more_ferr", ferr_cnt - f0, 1);

    // Overrun: consumer stalled across two frames.
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    tick(8);
    @(negedge clk);
    check("ovr_data_kept", rx_data, 8'h11);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_pulse", ovr_cnt - o0, 1);
    tick(1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    @(negedge clk);
    check("ovr_accept_data", last_acc, 8'h11);
    check("ovr_valid_drop", rx_valid, 0);
    tick(1);

    // Accept the held byte on the very cycle the next byte is delivered.
    o0 = ovr_cnt;
    send_frame(8'h00, 1'b1, 1'b1);
    fork
      send_frame(8'hFF, 1'b1, 1'b1);
      begin
        int n;
        n = 0;
        while (!busy && n < 400) begin @(negedge clk); n++; end
        while (busy && n < 400) begin @(negedge clk); n++; end
        check("b2b_watch_in_time", n < 400, 1);
        check("b2b_old_data", rx_data, 8'h00);
        check("b2b_old_valid", rx_valid, 1);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #2 rx_ready = 1'b0;
        @(negedge clk);
        check("b2b_new_data", rx_data, 8'hFF);
        check("b2b_new_valid", rx_valid, 1);
      end
    join
    check("b2b_no_ovr", ovr_cnt - o0, 0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    @(negedge clk);
    check("b2b_accept_ff", last_acc, 8'hFF);
    check("b2b_valid_drop", rx_valid, 0);
    tick(1);

    // Reset in the middle of a byte clears the held byte and aborts reception.
    send_frame(8'h5A, 1'b1, 1'b1);
    tick(4);
    @(negedge clk);
    check("pre_rst_valid", rx_valid, 1);
    check("pre_rst_data", rx_data, 8'h5A);
    tick(1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rx_i = 1'b1;
    @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    tick(3 * CPB);
    rx_ready = 1'b1;
    v0 = valid_cycles; f0 = ferr_cnt;
    send_frame(8'h81, 1'b1, 1'b1);
    tick(2 * CPB);
    check("post_rst_valid", valid_cycles - v0, 1);
    check("post_rst_data", last_acc, 8'h81);
    check("post_rst_ferr", ferr_cnt - f0, 0);

`ifdef UART_RX_PARITY_EN
    v0 = valid_cycles; p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    tick(2 * CPB);
    check("parity_err_pulse", perr_cnt - p0, 1);
    check("parity_no_valid", valid_cycles - v0, 0);
`else
    p0 = perr_cnt;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
